// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared geometry, FSM states and threshold helper for the DT result path
package dt_pkg;

    localparam int          IMG_PIX  = 16384;
    localparam int          WORD_W   = 16;
    localparam int          WORDS    = 1024;
    localparam logic [13:0] LAST_PIX = 14'd16383;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } dt_state_e;

    function automatic logic thresh_bit(input logic [7:0] v, input logic [7:0] t, input logic inv);
        return (v >= t) ^ inv;
    endfunction

endpackage

// File: rtl/dt_bit_packer.sv
// rtl/dt_bit_packer.sv - places serial pixel bits MSB-first into 16-bit words
module dt_bit_packer
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_bit_vld,
    input  logic              i_bit,
    input  logic [3:0]        i_bit_idx,
    output logic              o_word_vld,
    output logic [WORD_W-1:0] o_word
);

    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_word;
    logic              r_word_vld;
    logic [3:0]        w_pos;

    assign w_pos      = 4'd15 - i_bit_idx;
    assign o_word_vld = r_word_vld;
    assign o_word     = r_word;

    // Every position is rewritten each word, so the shift reg only needs clearing on a new sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift    <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= 1'b0;
            if (i_clear) begin
                r_shift <= '0;
            end else if (i_bit_vld) begin
                r_shift[w_pos] <= i_bit;
                if (i_bit_idx == 4'hF) begin
                    r_word_vld <= 1'b1;
                    r_word     <= {r_shift[WORD_W-1:1], i_bit};
                end
            end
        end
    end

endmodule

// File: rtl/dt_res_packer.sv
// rtl/dt_res_packer.sv - sweeps DT result RAM, thresholds and packs to bitmap; DT_PACK_CHECKSUM_EN adds pk_sum
module dt_res_packer
    import dt_pkg::*;
#(
    parameter logic [7:0] THRESH = 8'd1,
    parameter bit         INVERT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        pk_wr,
    output logic [9:0]  pk_addr,
    output logic [15:0] pk_do,
    output logic        busy,
    output logic        done,
    output logic [15:0] pk_sum
);

    dt_state_e   r_state;
    logic        r_res_rd;
    logic [13:0] r_res_addr;
    logic        r_smp_vld;
    logic [13:0] r_smp_addr;
    logic [9:0]  r_pk_addr;
    logic        r_busy;
    logic        r_done;

    logic        w_start_ok;
    logic        w_bit;
    logic        w_pk_wr;
    logic [15:0] w_pk_do;

    assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
    assign w_bit      = thresh_bit(res_di, THRESH, INVERT);

    assign res_rd   = r_res_rd;
    assign res_addr = r_res_addr;
    assign pk_wr    = w_pk_wr;
    assign pk_addr  = r_pk_addr;
    assign pk_do    = w_pk_do;
    assign busy     = r_busy;
    assign done     = r_done;

    // res_di belongs to the address issued one cycle earlier, so address tracks via r_smp_addr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_res_rd   <= 1'b0;
            r_res_addr <= '0;
            r_smp_vld  <= 1'b0;
            r_smp_addr <= '0;
            r_pk_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_smp_vld  <= r_res_rd;
            r_smp_addr <= r_res_addr;
            if (r_smp_vld && r_smp_addr[3:0] == 4'hF)
                r_pk_addr <= r_smp_addr[13:4];
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_res_rd   <= 1'b1;
                        r_res_addr <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (r_res_addr == LAST_PIX) begin
                        r_state  <= DRAIN;
                        r_res_rd <= 1'b0;
                    end else begin
                        r_res_addr <= r_res_addr + 14'd1;
                    end
                end
                DRAIN: r_state <= FLUSH;
                FLUSH: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dt_bit_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start_ok),
        .i_bit_vld  (r_smp_vld),
        .i_bit      (w_bit),
        .i_bit_idx  (r_smp_addr[3:0]),
        .o_word_vld (w_pk_wr),
        .o_word     (w_pk_do)
    );

`ifdef DT_PACK_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (w_start_ok) begin
            r_sum <= '0;
        end else if (w_pk_wr) begin
            r_sum <= r_sum + w_pk_do;
        end
    end

    assign pk_sum = r_sum;
`else
    assign pk_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_dt_res_packer.sv
// tb/tb_dt_res_packer.sv - table and random checks of dt_res_packer against a pixel-level model
module tb_dt_res_packer;
    import dt_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic        rd_a, rd_b, wr_a_s, wr_b_s, busy_a, busy_b, done_a, done_b;
    logic [13:0] addr_a, addr_b;
    logic [7:0]  di_a = 8'd0, di_b = 8'd0;
    logic [9:0]  pa_a, pa_b;
    logic [15:0] do_a, do_b, sum_a, sum_b;

    dt_res_packer #(.THRESH(8'd1), .INVERT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .res_rd(rd_a), .res_addr(addr_a), .res_di(di_a),
        .pk_wr(wr_a_s), .pk_addr(pa_a), .pk_do(do_a), .busy(busy_a), .done(done_a), .pk_sum(sum_a));

    dt_res_packer #(.THRESH(8'd4), .INVERT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .res_rd(rd_b), .res_addr(addr_b), .res_di(di_b),
        .pk_wr(wr_b_s), .pk_addr(pa_b), .pk_do(do_b), .busy(busy_b), .done(done_b), .pk_sum(sum_b));

    logic [7:0] mem [IMG_PIX];

    always @(posedge clk) begin
        if (rd_a) di_a <= mem[addr_a];
        if (rd_b) di_b <= mem[addr_b];
    end

    int cyc = 0;
    int s_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] got_a [WORDS];
    logic [15:0] got_b [WORDS];
    int wr_a, wr_b, ord_err, first_rd, last_wr;

    always @(negedge clk) begin
        if (wr_a_s) begin
            if (int'(pa_a) != wr_a) ord_err++;
            got_a[pa_a] = do_a;
            wr_a++;
            last_wr = cyc - s_cyc;
        end
        if (wr_b_s) begin
            got_b[pa_b] = do_b;
            wr_b++;
        end
        if (rd_a && first_rd < 0) first_rd = cyc - s_cyc;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input int w, input int t, input bit inv);
        logic [15:0] r;
        r = '0;
        for (int j = 0; j < 16; j++)
            r[15-j] = (int'(mem[w*16+j]) >= t) ^ inv;
        return r;
    endfunction

    task automatic fill(input int pat);
        for (int p = 0; p < IMG_PIX; p++) begin
            case (pat)
                1: mem[p] = 8'd5;
                2: mem[p] = (p == 0) ? 8'd3 : ((p == IMG_PIX-1) ? 8'd1 : 8'd0);
                3: mem[p] = 8'(((p / 128) ^ (p % 128)) & 1);
                4: mem[p] = 8'($urandom_range(0, 7));
                default: mem[p] = 8'd0;
            endcase
        end
    endtask

    int done_rel, busy1, busy_end;

    task automatic sweep(input int rst_at, input bit pulses);
        int rel;
        wr_a = 0; wr_b = 0; ord_err = 0; first_rd = -1; last_wr = -1;
        done_rel = -1; busy1 = -1; busy_end = -1;
        for (int i = 0; i < WORDS; i++) begin
            got_a[i] = 16'hDEAD;
            got_b[i] = 16'hDEAD;
        end
        @(negedge clk);
        s_cyc = cyc;
        start = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            rel = cyc - s_cyc;
            start = pulses && (rel == 100 || rel == 3000 || rel == 16385);
            if (rel == 1) busy1 = int'(busy_a);
            if (rel == rst_at) begin
                reset = 1'b0;
                break;
            end
            if (done_a && done_b) begin
                done_rel = rel;
                busy_end = int'(busy_a | busy_b);
                break;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        int          pat;
        bit          pulses;
        bit          use_model;
        logic [15:0] a_w0, a_w1, a_wl, b_w0, a_sum;
    } vec_t;

    vec_t tbl [4];

    task automatic check_sweep(input string tag, input logic [15:0] a_w0, input logic [15:0] a_w1,
                               input logic [15:0] a_wl, input logic [15:0] b_w0, input logic [15:0] a_sum);
        int mm_a, mm_b;
        logic [15:0] exp_sum;
        mm_a = 0; mm_b = 0;
        for (int w = 0; w < WORDS; w++) begin
            if (got_a[w] !== model_word(w, 1, 1'b0)) mm_a++;
            if (got_b[w] !== model_word(w, 4, 1'b1)) mm_b++;
        end
`ifdef DT_PACK_CHECKSUM_EN
        exp_sum = a_sum;
`else
        exp_sum = 16'h0000;
`endif
        check({tag, " done_cycle"}, 64'(done_rel), 64'd16387);
        check({tag, " first_rd"},   64'(first_rd), 64'd1);
        check({tag, " last_wr"},    64'(last_wr),  64'd16386);
        check({tag, " busy"},       64'({busy1, busy_end}), {32'd1, 32'd0});
        check({tag, " writes"},     64'({wr_a, wr_b}), {32'd1024, 32'd1024});
        check({tag, " addr_order"}, 64'(ord_err),  64'd0);
        check({tag, " a_word0"},    64'(got_a[0]),    64'(a_w0));
        check({tag, " a_word1"},    64'(got_a[1]),    64'(a_w1));
        check({tag, " a_word1023"}, 64'(got_a[1023]), 64'(a_wl));
        check({tag, " b_word0"},    64'(got_b[0]),    64'(b_w0));
        check({tag, " model_a"},    64'(mm_a), 64'd0);
        check({tag, " model_b"},    64'(mm_b), 64'd0);
        check({tag, " pk_sum"},     64'(sum_a), 64'(exp_sum));
    endtask

    initial begin
        logic [15:0] ms;
        int snap;

        tbl[0] = '{1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFC00};
        tbl[1] = '{2, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h8001};
        tbl[2] = '{3, 1'b0, 1'b0, 16'h5555, 16'h5555, 16'hAAAA, 16'hFFFF, 16'hFE00};
        tbl[3] = '{4, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        repeat (3) @(negedge clk);
        check("reset_outputs", {4'h0, rd_a, wr_a_s, busy_a, done_a, addr_a, pa_a, do_a, sum_a}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            fill(tbl[v].pat);
            if (tbl[v].use_model) begin
                ms = '0;
                for (int w = 0; w < WORDS; w++) ms = ms + model_word(w, 1, 1'b0);
                tbl[v].a_w0  = model_word(0, 1, 1'b0);
                tbl[v].a_w1  = model_word(1, 1, 1'b0);
                tbl[v].a_wl  = model_word(WORDS-1, 1, 1'b0);
                tbl[v].b_w0  = model_word(0, 4, 1'b1);
                tbl[v].a_sum = ms;
            end
            sweep(-1, tbl[v].pulses);
            check_sweep($sformatf("vec%0d", v), tbl[v].a_w0, tbl[v].a_w1, tbl[v].a_wl, tbl[v].b_w0, tbl[v].a_sum);
        end

        fill(0);
        sweep(5000, 1'b0);
        @(negedge clk);
        check("midreset_outputs", {4'h0, rd_a, wr_a_s, busy_a, done_a, addr_a, pa_a, do_a, sum_a}, 64'd0);
        snap = wr_a;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_idle", 64'({wr_a - snap, 31'd0, busy_a | done_a}), 64'd0);

        sweep(-1, 1'b0);
        check_sweep("restart", 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
